// File: rtl/timeout_timer.sv
// Programmable timeout timer: prescaler derives a tick from clk_50M and counts ticks to a latched term.
// Define TIMEOUT_TIMER_COUNTDOWN_EN to make o_Count show remaining ticks instead of elapsed ticks.
module timeout_timer #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 2000,
  parameter int WIDTH   = 12
) (
  input  logic             clk_50M,
  input  logic             i_Zero,
  input  logic             i_Start,
  input  logic             i_Stop,
  input  logic             i_Pause,
  input  logic             i_Mode,
  input  logic [WIDTH-1:0] i_Term,
  output logic [WIDTH-1:0] o_Count,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Expire,
  output logic             o_Tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("timeout_timer: CLK_HZ/TICK_HZ must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

  state_t           r_State, w_State_n;
  logic [PW-1:0]    r_Presc, w_Presc_n;
  logic [WIDTH-1:0] r_Cnt, w_Cnt_n;
  logic [WIDTH-1:0] r_Term, w_Term_n;
  logic             r_Mode, w_Mode_n;
  logic             w_Tick_n, w_Expire_n;
  logic             w_Active_n;
  logic [WIDTH-1:0] w_OutCnt_n;
  logic [WIDTH-1:0] r_OutCnt;
  logic             r_Busy, r_Done, r_Expire, r_Tick;

  // Counting advances whenever busy and not paused, so leaving PAUSED costs no extra cycle.
  always_comb begin
    w_State_n  = r_State;
    w_Presc_n  = r_Presc;
    w_Cnt_n    = r_Cnt;
    w_Term_n   = r_Term;
    w_Mode_n   = r_Mode;
    w_Tick_n   = 1'b0;
    w_Expire_n = 1'b0;
    if (i_Stop) begin
      w_State_n = S_IDLE;
      w_Presc_n = '0;
      w_Cnt_n   = '0;
    end else if (i_Start) begin
      w_State_n = S_RUN;
      w_Presc_n = '0;
      w_Cnt_n   = '0;
      w_Term_n  = i_Term;
      w_Mode_n  = i_Mode;
    end else if (r_State == S_RUN || r_State == S_PAUSED) begin
      if (r_Term == '0) begin
        w_Expire_n = 1'b1;
        w_State_n  = r_Mode ? S_IDLE : S_DONE;
      end else if (i_Pause) begin
        w_State_n = S_PAUSED;
      end else begin
        w_State_n = S_RUN;
        if (r_Presc == PRESC_MAX) begin
          w_Presc_n = '0;
          w_Tick_n  = 1'b1;
          if (r_Cnt == r_Term - WIDTH'(1)) begin
            w_Expire_n = 1'b1;
            if (r_Mode) begin
              w_Cnt_n = '0;
            end else begin
              w_Cnt_n   = r_Term;
              w_State_n = S_DONE;
            end
          end else begin
            w_Cnt_n = r_Cnt + WIDTH'(1);
          end
        end else begin
          w_Presc_n = r_Presc + PW'(1);
        end
      end
    end
  end

  assign w_Active_n = (w_State_n == S_RUN) || (w_State_n == S_PAUSED);

`ifdef TIMEOUT_TIMER_COUNTDOWN_EN
  assign w_OutCnt_n = w_Active_n ? (w_Term_n - w_Cnt_n) : '0;
`else
  assign w_OutCnt_n = w_Cnt_n;
`endif

  always_ff @(posedge clk_50M or posedge i_Zero) begin
    if (i_Zero) begin
      r_State  <= S_IDLE;
      r_Presc  <= '0;
      r_Cnt    <= '0;
      r_Term   <= '0;
      r_Mode   <= 1'b0;
      r_OutCnt <= '0;
      r_Busy   <= 1'b0;
      r_Done   <= 1'b0;
      r_Expire <= 1'b0;
      r_Tick   <= 1'b0;
    end else begin
      r_State  <= w_State_n;
      r_Presc  <= w_Presc_n;
      r_Cnt    <= w_Cnt_n;
      r_Term   <= w_Term_n;
      r_Mode   <= w_Mode_n;
      r_OutCnt <= w_OutCnt_n;
      r_Busy   <= w_Active_n;
      r_Done   <= (w_State_n == S_DONE);
      r_Expire <= w_Expire_n;
      r_Tick   <= w_Tick_n;
    end
  end

  assign o_Count  = r_OutCnt;
  assign o_Busy   = r_Busy;
  assign o_Done   = r_Done;
  assign o_Expire = r_Expire;
  assign o_Tick   = r_Tick;

endmodule

// File: tb/tb_timeout_timer.sv
// Directed bench for timeout_timer with DIV=10, WIDTH=4; cycle n is the n-th rising edge after the i_Start edge.
module tb_timeout_timer;

  logic       clk_50M = 1'b0;
  logic       i_Zero  = 1'b0;
  logic       i_Start = 1'b0;
  logic       i_Stop  = 1'b0;
  logic       i_Pause = 1'b0;
  logic       i_Mode  = 1'b0;
  logic [3:0] i_Term  = 4'd0;
  logic [3:0] o_Count;
  logic       o_Busy, o_Done, o_Expire, o_Tick;

  int n_assert = 0;
  int n_fail   = 0;
  int el;
  int seen;

  timeout_timer #(.CLK_HZ(10), .TICK_HZ(1), .WIDTH(4)) dut (
    .clk_50M (clk_50M),
    .i_Zero  (i_Zero),
    .i_Start (i_Start),
    .i_Stop  (i_Stop),
    .i_Pause (i_Pause),
    .i_Mode  (i_Mode),
    .i_Term  (i_Term),
    .o_Count (o_Count),
    .o_Busy  (o_Busy),
    .o_Done  (o_Done),
    .o_Expire(o_Expire),
    .o_Tick  (o_Tick)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Expected o_Count: elapsed ticks, or remaining ticks (0 when not busy) in the countdown build.
  function automatic logic [31:0] exp_cnt(input bit active, input int elapsed, input int t);
    logic [31:0] up;
    logic [31:0] down;
    up   = 32'(elapsed);
    down = active ? 32'(t - elapsed) : 32'd0;
`ifdef TIMEOUT_TIMER_COUNTDOWN_EN
    return down;
`else
    return up;
`endif
  endfunction

  // Called at a falling edge; returns at the falling edge of cycle 0.
  task automatic do_start(input logic [3:0] t, input logic m);
    i_Term  = t;
    i_Mode  = m;
    i_Start = 1'b1;
    @(negedge clk_50M);
    i_Start = 1'b0;
  endtask

  task automatic do_stop();
    i_Stop = 1'b1;
    @(negedge clk_50M);
    i_Stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 i_Zero = 1'b1;
    @(negedge clk_50M);
    chk("rst count", o_Count, 0);
    chk("rst busy", o_Busy, 0);
    chk("rst done", o_Done, 0);
    chk("rst expire", o_Expire, 0);
    chk("rst tick", o_Tick, 0);
    i_Zero = 1'b0;
    @(negedge clk_50M);

    // One-shot, term 3; the i_Term change after start must be ignored
    do_start(4'd3, 1'b0);
    i_Term = 4'd9;
    for (int c = 0; c <= 40; c++) begin
      el = (c < 30) ? c / 10 : 3;
      chk($sformatf("os tick c%0d", c), o_Tick, (c == 10 || c == 20 || c == 30));
      chk($sformatf("os expire c%0d", c), o_Expire, (c == 30));
      chk($sformatf("os done c%0d", c), o_Done, (c >= 30));
      chk($sformatf("os busy c%0d", c), o_Busy, (c < 30));
      chk($sformatf("os count c%0d", c), o_Count, exp_cnt(c < 30, el, 3));
      if (c < 40) @(negedge clk_50M);
    end
    do_stop();
    chk("stop done", o_Done, 0);
    chk("stop count", o_Count, 0);
    chk("stop busy", o_Busy, 0);

    // Periodic, term 2
    do_start(4'd2, 1'b1);
    for (int c = 0; c <= 65; c++) begin
      el = (c / 10) % 2;
      chk($sformatf("per expire c%0d", c), o_Expire, (c > 0 && c % 20 == 0));
      chk($sformatf("per tick c%0d", c), o_Tick, (c > 0 && c % 10 == 0));
      chk($sformatf("per done c%0d", c), o_Done, 0);
      chk($sformatf("per busy c%0d", c), o_Busy, 1);
      chk($sformatf("per count c%0d", c), o_Count, exp_cnt(1'b1, el, 2));
      if (c < 65) @(negedge clk_50M);
    end
    do_stop();

    // One-shot, term 3, paused for 7 edges starting at cycle 15
    do_start(4'd3, 1'b0);
    for (int c = 0; c <= 40; c++) begin
      el = (c < 10) ? 0 : (c < 27) ? 1 : (c < 37) ? 2 : 3;
      chk($sformatf("pz tick c%0d", c), o_Tick, (c == 10 || c == 27 || c == 37));
      chk($sformatf("pz expire c%0d", c), o_Expire, (c == 37));
      chk($sformatf("pz busy c%0d", c), o_Busy, (c < 37));
      chk($sformatf("pz done c%0d", c), o_Done, (c >= 37));
      chk($sformatf("pz count c%0d", c), o_Count, exp_cnt(c < 37, el, 3));
      if (c == 15) i_Pause = 1'b1;
      if (c == 22) i_Pause = 1'b0;
      if (c < 40) @(negedge clk_50M);
    end
    do_stop();

    // Stop and start together at cycle 12: stop wins
    do_start(4'd3, 1'b0);
    repeat (11) @(negedge clk_50M);
    i_Stop  = 1'b1;
    i_Start = 1'b1;
    @(negedge clk_50M);
    i_Stop  = 1'b0;
    i_Start = 1'b0;
    chk("ss busy", o_Busy, 0);
    chk("ss count", o_Count, 0);
    chk("ss done", o_Done, 0);
    chk("ss expire", o_Expire, 0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_50M);
      if (o_Expire !== 1'b0 || o_Busy !== 1'b0) seen++;
    end
    chk("ss idle quiet", seen, 0);
    do_start(4'd3, 1'b0);
    chk("rs busy c0", o_Busy, 1);
    chk("rs count c0", o_Count, exp_cnt(1'b1, 0, 3));
    repeat (10) @(negedge clk_50M);
    chk("rs tick c10", o_Tick, 1);
    chk("rs count c10", o_Count, exp_cnt(1'b1, 1, 3));
    do_stop();

    // term 0, one-shot
    do_start(4'd0, 1'b0);
    chk("t0 busy c0", o_Busy, 1);
    chk("t0 expire c0", o_Expire, 0);
    chk("t0 done c0", o_Done, 0);
    @(negedge clk_50M);
    chk("t0 expire c1", o_Expire, 1);
    chk("t0 done c1", o_Done, 1);
    chk("t0 busy c1", o_Busy, 0);
    chk("t0 tick c1", o_Tick, 0);
    chk("t0 count c1", o_Count, 0);
    @(negedge clk_50M);
    chk("t0 expire c2", o_Expire, 0);
    chk("t0 done c2", o_Done, 1);
    do_stop();

    // term 0, periodic: expire then back to idle
    do_start(4'd0, 1'b1);
    @(negedge clk_50M);
    chk("t0p expire c1", o_Expire, 1);
    chk("t0p done c1", o_Done, 0);
    chk("t0p busy c1", o_Busy, 0);
    @(negedge clk_50M);
    chk("t0p expire c2", o_Expire, 0);
    chk("t0p busy c2", o_Busy, 0);

    // term 15 (max), one-shot
    do_start(4'd15, 1'b0);
    repeat (149) @(negedge clk_50M);
    chk("t15 count c149", o_Count, exp_cnt(1'b1, 14, 15));
    chk("t15 expire c149", o_Expire, 0);
    chk("t15 busy c149", o_Busy, 1);
    @(negedge clk_50M);
    chk("t15 expire c150", o_Expire, 1);
    chk("t15 tick c150", o_Tick, 1);
    chk("t15 done c150", o_Done, 1);
    chk("t15 count c150", o_Count, exp_cnt(1'b0, 15, 15));
    @(negedge clk_50M);
    chk("t15 expire c151", o_Expire, 0);
    chk("t15 count c151", o_Count, exp_cnt(1'b0, 15, 15));
    chk("t15 done c151", o_Done, 1);
    do_stop();

    // Asynchronous reset mid-run at cycle 25
    do_start(4'd3, 1'b0);
    repeat (24) @(negedge clk_50M);
    chk("ar busy c24", o_Busy, 1);
    chk("ar count c24", o_Count, exp_cnt(1'b1, 2, 3));
    #2 i_Zero = 1'b1;
    #1;
    chk("ar count", o_Count, 0);
    chk("ar busy", o_Busy, 0);
    chk("ar done", o_Done, 0);
    chk("ar expire", o_Expire, 0);
    chk("ar tick", o_Tick, 0);
    @(negedge clk_50M);
    i_Zero = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_50M);
      if (o_Expire !== 1'b0 || o_Busy !== 1'b0) seen++;
    end
    chk("ar quiet after", seen, 0);

    // Count sequence across a one-shot run with term 3
    do_start(4'd3, 1'b0);
    chk("seq c0", o_Count, exp_cnt(1'b1, 0, 3));
    repeat (10) @(negedge clk_50M);
    chk("seq c10", o_Count, exp_cnt(1'b1, 1, 3));
    repeat (10) @(negedge clk_50M);
    chk("seq c20", o_Count, exp_cnt(1'b1, 2, 3));
    repeat (10) @(negedge clk_50M);
    chk("seq c30", o_Count, exp_cnt(1'b0, 3, 3));
    do_stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/timeout_timer.md
Name: timeout_timer

Overview:
- Parametrised successor of the fixed 2-second counter: a single-clock programmable timeout timer for the BlackJack FSM (deal delays, dealer pause, reveal timing).
- Internal prescaler derives a tick from the 50 MHz clock and counts ticks up to a terminal value latched at start.
- Supports one-shot and periodic modes, pause/resume, abort and restart.
- Replaces the two-clock-domain counter, so the FSM no longer needs an external 2 kHz clock.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 2000, tick rate in Hz; DIV = CLK_HZ/TICK_HZ, must be >= 1 (elaboration error otherwise).
- WIDTH, 12, width of the tick counter and terminal value.

Ports:
- clk_50M  input  1  system clock; all logic on its rising edge.
- i_Zero  input  1  reset, asynchronous, active-high.
- i_Start  input  1  one-cycle start/restart request; latches i_Term and i_Mode.
- i_Stop  input  1  abort; returns to IDLE.
- i_Pause  input  1  level; freezes prescaler and count while high in RUN.
- i_Mode  input  1  0 = one-shot, 1 = periodic.
- i_Term  input  WIDTH  terminal tick count.
- o_Count  output  WIDTH  elapsed ticks (see Optional Feature).
- o_Busy  output  1  high in RUN or PAUSED.
- o_Done  output  1  one-shot completion level.
- o_Expire  output  1  one-cycle pulse on every expiry.
- o_Tick  output  1  one-cycle prescaler tick pulse, only while counting.

Behaviour:
- Reset: state IDLE; prescaler, count, latched term/mode = 0; o_Count = 0, o_Busy = 0, o_Done = 0, o_Expire = 0, o_Tick = 0. Reset mid-operation aborts immediately with no o_Expire.
- States: IDLE, RUN, PAUSED, DONE.
- IDLE -> RUN on i_Start. Prescaler and count clear; term and mode latch.
- RUN -> PAUSED when i_Pause = 1. PAUSED -> RUN when i_Pause = 0. Prescaler and count are held, not cleared.
- In RUN, the prescaler counts 0..DIV-1. o_Tick is asserted in the cycle the prescaler equals DIV-1, then the prescaler wraps to 0.
- Count increments once per tick.
- Expiry is the tick on which count == term-1. Latency from the i_Start cycle to o_Expire is term*DIV cycles, excluding paused cycles.
- One-shot expiry: count becomes term; state goes to DONE; o_Done = 1; o_Expire pulses for one cycle.
- Periodic expiry: count wraps to 0; o_Expire pulses; state stays RUN; o_Done stays 0.
- DONE: count holds at term and o_Done holds 1 until i_Start or i_Stop.
- term = 0: no counting. One cycle after i_Start, o_Expire pulses and the state goes to DONE (one-shot) or IDLE (periodic).
- i_Start in any state restarts: clears o_Done, prescaler and count; relatches term and mode.
- i_Stop in any state -> IDLE, with count, prescaler and o_Done cleared.
- i_Stop and i_Start in the same cycle: i_Stop wins.
- i_Pause is ignored in IDLE and DONE.
- i_Pause and i_Start in the same cycle: restart into RUN; pause applies from the next cycle.
- i_Term and i_Mode changes after start have no effect until the next i_Start.
- Counter arithmetic is unsigned WIDTH bits; count never exceeds term.
- The prescaler is ceil(log2(DIV)) bits wide, minimum 1 bit.
- All outputs are registered.

Optional Feature:
- Macro TIMEOUT_TIMER_COUNTDOWN_EN.
- Defined: o_Count shows remaining ticks, term - count. It is 0 in DONE and in IDLE after reset or stop, and equals term right after start.
- Undefined: o_Count shows elapsed count as above.
- All other outputs are identical in both builds.

Test Plan:
- Bench parameters CLK_HZ=10, TICK_HZ=1 (DIV=10), WIDTH=4; reset, then one-shot start with i_Term=3 -> o_Tick at cycles 10, 20, 30; o_Expire and o_Done at cycle 30; o_Count=3 held; o_Busy low after.
- Periodic, i_Term=2 -> o_Expire pulses at cycles 20, 40, 60; o_Count sequence 0,1,0,1; o_Done never set.
- One-shot, i_Term=3, i_Pause high for 7 cycles starting at cycle 15 -> expiry moves to cycle 37; o_Count frozen at 1 during pause.
- i_Stop and i_Start asserted together at cycle 12 of a run -> IDLE, o_Count=0, no o_Expire; next i_Start alone restarts from 0.
- i_Term=0, one-shot -> o_Expire and o_Done one cycle after start; i_Term=15 (max) -> expiry at cycle 150 with count exactly 15, no wrap.
- i_Zero pulsed mid-RUN at cycle 25 -> all outputs 0 immediately (asynchronous); with TIMEOUT_TIMER_COUNTDOWN_EN, i_Term=3 gives o_Count 3,2,1,0.
